// File: rtl/des_pkg.sv
// Shared DES constants for the key schedule: PC-1/PC-2 tables, per-round shift counts, FSM states.
package des_pkg;

   localparam int unsigned Pc1Table [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned Pc2Table [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Entry n-1 holds the rotation count for round n.
   localparam int unsigned ShiftSched [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   typedef enum logic [1:0] {StIdle, StRun, StDone} ks_state_e;

   function automatic logic [1:0] shift_amt(logic [3:0] idx);
      return 2'(ShiftSched[idx]);
   endfunction

endpackage

// File: rtl/p_box_56_48.sv
// Fixed 56-to-48 permutation (PC-2); FIPS bit numbering, bit 1 is the MSB.
module p_box_56_48
   import des_pkg::*;
(
   input  logic [1:56] data_i,
   output logic [1:48] data_o
);

   for (genvar i = 0; i < 48; i++) begin : g_map
      assign data_o[i+1] = data_i[Pc2Table[i]];
   end

   logic unused_dropped;
   assign unused_dropped = ^{data_i[9], data_i[18], data_i[22], data_i[25],
                             data_i[35], data_i[38], data_i[43], data_i[54]};

endmodule

// File: rtl/p_box_64_56.sv
// Fixed 64-to-56 permutation (PC-1); FIPS bit numbering, bit 1 is the MSB.
module p_box_64_56
   import des_pkg::*;
(
   input  logic [1:64] data_i,
   output logic [1:56] data_o
);

   for (genvar i = 0; i < 56; i++) begin : g_map
      assign data_o[i+1] = data_i[Pc1Table[i]];
   end

   // Parity bits never reach the output.
   logic unused_parity;
   assign unused_parity = ^{data_i[8], data_i[16], data_i[24], data_i[32],
                            data_i[40], data_i[48], data_i[56], data_i[64]};

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: one subkey per ready/valid transfer, K1..K16 or K16..K1.
module des_key_schedule
   import des_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        decrypt_i,
   input  logic [1:64] key_i,
   output logic        busy_o,
   output logic [1:48] subkey_o,
   output logic        subkey_valid_o,
   input  logic        subkey_ready_i,
   output logic [3:0]  round_o,
   output logic        done_o
);

   ks_state_e   state_q;
   logic [27:0] c_q, d_q;
   logic [3:0]  cnt_q;   // current round minus 1
   logic        dec_q;

   logic [1:56] pc1_key;
   logic [1:48] pc2_key;
   logic [27:0] c_load, d_load, c_rot, d_rot;
   logic [1:0]  shamt;

   p_box_64_56 u_pc1 (.data_i(key_i), .data_o(pc1_key));
   p_box_56_48 u_pc2 (.data_i({c_q, d_q}), .data_o(pc2_key));

   // Encrypt preloads C1/D1 (left by s[1]); decrypt starts at C0/D0 == C16/D16.
   always_comb begin
      if (decrypt_i) begin
         c_load = pc1_key[1:28];
         d_load = pc1_key[29:56];
      end else begin
         c_load = {pc1_key[2:28], pc1_key[1]};
         d_load = {pc1_key[30:56], pc1_key[29]};
      end
   end

   // Decrypt's round-16 step (right by s[1]) returns C/D to C0/D0; encrypt is already there.
   always_comb begin
      if (dec_q)                shamt = shift_amt(4'd15 - cnt_q);
      else if (cnt_q == 4'd15)  shamt = 2'd0;
      else                      shamt = shift_amt(cnt_q + 4'd1);
   end

   always_comb begin
      c_rot = c_q;
      d_rot = d_q;
      case (shamt)
         2'd1: begin
            c_rot = dec_q ? {c_q[0], c_q[27:1]} : {c_q[26:0], c_q[27]};
            d_rot = dec_q ? {d_q[0], d_q[27:1]} : {d_q[26:0], d_q[27]};
         end
         2'd2: begin
            c_rot = dec_q ? {c_q[1:0], c_q[27:2]} : {c_q[25:0], c_q[27:26]};
            d_rot = dec_q ? {d_q[1:0], d_q[27:2]} : {d_q[25:0], d_q[27:26]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= StIdle;
         c_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: if (start_i) begin
               c_q     <= c_load;
               d_q     <= d_load;
               dec_q   <= decrypt_i;
               cnt_q   <= '0;
               state_q <= StRun;
            end
            StRun: if (subkey_ready_i) begin
               c_q <= c_rot;
               d_q <= d_rot;
               if (cnt_q == 4'd15) state_q <= StDone;
               else                cnt_q   <= cnt_q + 4'd1;
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o         = (state_q == StRun);
   assign subkey_valid_o = (state_q == StRun);
   assign done_o         = (state_q == StDone);
   assign subkey_o       = (state_q == StRun) ? pc2_key : '0;
   assign round_o        = (state_q == StRun) ? (dec_q ? 4'd15 - cnt_q : cnt_q) : 4'd0;

`ifndef SYNTHESIS
   logic [55:0] cd0_q;
   always_ff @(posedge clk_i) begin
      if (rst_n_i && state_q == StIdle && start_i) cd0_q <= pc1_key;
   end
   always_ff @(posedge clk_i) begin
      if (rst_n_i && state_q == StDone) begin
         assert ({c_q, d_q} == cd0_q) else $error("C/D not back at C0/D0 after schedule");
      end
   end
`endif

endmodule
